// File: rtl/vdrive_pkg.sv
// rtl/vdrive_pkg.sv - shared constants and fetch FSM state type for the video drive path
package vdrive_pkg;

  localparam int FB_W        = 128;
  localparam int FB_H        = 64;
  localparam int LORES_BYTES = 8;
  localparam int HIRES_BYTES = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/line_buf_2p.sv
// rtl/line_buf_2p.sv - one 2-plane x 128-bit line buffer, byte write, pixel read
module line_buf_2p
  import vdrive_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wr_en,
  input  logic       wr_plane,
  input  logic [3:0] wr_byte,
  input  logic [7:0] wr_data,
  input  logic [6:0] rd_col,
  output logic [1:0] rd_pixel
);

  localparam int NBYTES = FB_W / 8;

  logic [NBYTES-1:0][7:0] plane0_q, plane0_d;
  logic [NBYTES-1:0][7:0] plane1_q, plane1_d;

  // byte write into the selected plane, everything else holds
  always_comb begin
    plane0_d = plane0_q;
    plane1_d = plane1_q;
    if (wr_en) begin
      if (wr_plane) plane1_d[wr_byte] = wr_data;
      else          plane0_d[wr_byte] = wr_data;
    end
  end

  // plane storage, cleared to a blank line on reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      plane0_q <= '0;
      plane1_q <= '0;
    end else begin
      plane0_q <= plane0_d;
      plane1_q <= plane1_d;
    end
  end

  // column c lives in byte c/8; the byte MSB is the leftmost pixel
  assign rd_pixel = {plane1_q[rd_col[6:3]][~rd_col[2:0]],
                     plane0_q[rd_col[6:3]][~rd_col[2:0]]};

endmodule

// File: rtl/vram_line_fetch.sv
// rtl/vram_line_fetch.sv - double-buffered scanline fetch from display memory; VRAM_FETCH_UNDERRUN_EN enables the sticky underrun flag
module vram_line_fetch
  import vdrive_pkg::*;
#(
  parameter logic [11:0] FB_BASE = 12'h000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        hires,
  input  logic        line_start,
  input  logic [5:0]  line_vpos,
  input  logic [6:0]  vram_hpos,
  output logic [1:0]  vram_pixel,
  output logic        mem_req,
  output logic [11:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        underrun
);

  fetch_state_e state_q, state_d;
  logic        front_sel_q, front_sel_d;
  logic        front_hires_q, front_hires_d;
  logic        hires_q, hires_d;
  logic [5:0]  row_q, row_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        drain_q, drain_d;
  logic [11:0] addr_q, addr_d;
  logic [1:0]  pix_q, pix_d;

  logic        wr_en;
  logic        cur_plane;
  logic [3:0]  cur_byte;
  logic        last_byte;
  logic [1:0]  pix0, pix1, front_pix;

  // map the running byte counter onto plane/byte for the latched mode
  always_comb begin
    cur_plane = hires_q ? cnt_q[4] : cnt_q[3];
    cur_byte  = hires_q ? cnt_q[3:0] : {1'b0, cnt_q[2:0]};
    last_byte = hires_q ? (cnt_q == 5'(2*HIRES_BYTES-1))
                        : (cnt_q == 5'(2*LORES_BYTES-1));
  end

  // fetch FSM: next state, request handshake and back-buffer write strobe
  always_comb begin
    state_d       = state_q;
    front_sel_d   = front_sel_q;
    front_hires_d = front_hires_q;
    hires_d       = hires_q;
    row_d         = row_q;
    cnt_d         = cnt_q;
    req_d         = req_q;
    drain_d       = drain_q;
    addr_d        = addr_q;
    wr_en         = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (line_start) begin
          if (state_q == DONE) begin
            front_sel_d   = ~front_sel_q;
            front_hires_d = hires_q;
          end
          hires_d = hires;
          row_d   = line_vpos;
          cnt_d   = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (line_start) begin
          // restart on the new row; an outstanding request is held until
          // its ack and that data is discarded
          hires_d = hires;
          row_d   = line_vpos;
          cnt_d   = '0;
          if (req_q) begin
            if (mem_ack) begin
              req_d   = 1'b0;
              drain_d = 1'b0;
            end else begin
              drain_d = 1'b1;
            end
          end
        end else if (req_q && mem_ack) begin
          req_d = 1'b0;
          if (drain_q) begin
            drain_d = 1'b0;
          end else begin
            wr_en = 1'b1;
            cnt_d = cnt_q + 5'd1;
            if (last_byte) state_d = DONE;
          end
        end else if (!req_q) begin
          req_d  = 1'b1;
          addr_d = FB_BASE + {1'b0, cur_plane, row_q, cur_byte};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // in lores only the left 64 columns carry image data
  always_comb begin
    front_pix = front_sel_q ? pix1 : pix0;
    pix_d     = (front_hires_q || !vram_hpos[6]) ? front_pix : 2'b00;
  end

  // state and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      front_sel_q   <= 1'b0;
      front_hires_q <= 1'b0;
      hires_q       <= 1'b0;
      row_q         <= '0;
      cnt_q         <= '0;
      req_q         <= 1'b0;
      drain_q       <= 1'b0;
      addr_q        <= '0;
      pix_q         <= '0;
    end else begin
      state_q       <= state_d;
      front_sel_q   <= front_sel_d;
      front_hires_q <= front_hires_d;
      hires_q       <= hires_d;
      row_q         <= row_d;
      cnt_q         <= cnt_d;
      req_q         <= req_d;
      drain_q       <= drain_d;
      addr_q        <= addr_d;
      pix_q         <= pix_d;
    end
  end

  line_buf_2p u_buf0 (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (wr_en && front_sel_q),
    .wr_plane (cur_plane),
    .wr_byte  (cur_byte),
    .wr_data  (mem_rdata),
    .rd_col   (vram_hpos),
    .rd_pixel (pix0)
  );

  line_buf_2p u_buf1 (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (wr_en && !front_sel_q),
    .wr_plane (cur_plane),
    .wr_byte  (cur_byte),
    .wr_data  (mem_rdata),
    .rd_col   (vram_hpos),
    .rd_pixel (pix1)
  );

  assign vram_pixel = pix_q;
  assign mem_req    = req_q;
  assign mem_addr   = addr_q;

`ifdef VRAM_FETCH_UNDERRUN_EN
  logic underrun_q, underrun_d;

  // sticky: any line_start that finds a fetch still running
  always_comb begin
    underrun_d = underrun_q;
    if (line_start && state_q == FETCH) underrun_d = 1'b1;
  end

  // underrun flag register, cleared only by reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) underrun_q <= 1'b0;
    else          underrun_q <= underrun_d;
  end

  assign underrun = underrun_q;
`else
  assign underrun = 1'b0;
`endif

endmodule

// File: tb/tb_vram_line_fetch.sv
// tb/tb_vram_line_fetch.sv - randomized self-checking bench for vram_line_fetch
module tb_vram_line_fetch;

  localparam logic [11:0] FB_BASE = 12'h000;
`ifdef VRAM_FETCH_UNDERRUN_EN
  localparam int UR_EN = 1;
`else
  localparam int UR_EN = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        hires;
  logic        line_start;
  logic [5:0]  line_vpos;
  logic [6:0]  vram_hpos;
  logic [1:0]  vram_pixel;
  logic        mem_req;
  logic [11:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        underrun;

  vram_line_fetch #(.FB_BASE(FB_BASE)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .hires      (hires),
    .line_start (line_start),
    .line_vpos  (line_vpos),
    .vram_hpos  (vram_hpos),
    .vram_pixel (vram_pixel),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  logic [7:0]  mem [4096];
  logic [11:0] acc_q [$];
  bit          ack_hold  = 1'b0;
  bit          force_ack = 1'b0;
  int          lat_max   = 0;
  int          wait_cnt  = 0;
  int          viol      = 0;
  logic        prev_req  = 1'b0;
  logic        prev_ack  = 1'b0;
  logic [11:0] prev_addr = '0;

  int cur_row, pend_row, front_row;
  bit cur_hr, pend_hr, front_hr, pend_valid, front_valid, fetch_done;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] exp_addr(input int row, input bit hr, input int k);
    int n;
    n = hr ? 16 : 8;
    return 12'((int'(FB_BASE) + (k / n) * 1024 + row * 16 + (k % n)) % 4096);
  endfunction

  function automatic logic [1:0] ref_pix(input bit valid, input bit hr, input int row, input int col);
    logic [7:0] b0, b1;
    int a0;
    if (!valid || (!hr && col >= 64)) return 2'b00;
    a0 = (int'(FB_BASE) + row * 16 + col / 8) % 4096;
    b0 = mem[a0];
    b1 = mem[(a0 + 1024) % 4096];
    return {b1[7 - col % 8], b0[7 - col % 8]};
  endfunction

  // memory responder and handshake monitor
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (reset_n && prev_req && !prev_ack && (!mem_req || mem_addr != prev_addr)) viol++;
      if (reset_n && prev_ack && mem_req) viol++;
      mem_ack = 1'b0;
      if (force_ack) begin
        mem_ack   = 1'b1;
        mem_rdata = 8'hFF;
      end else if (reset_n && mem_req && !ack_hold) begin
        if (wait_cnt == 0) begin
          mem_ack   = 1'b1;
          mem_rdata = mem[mem_addr];
          acc_q.push_back(mem_addr);
          wait_cnt  = $urandom_range(0, lat_max);
        end else begin
          wait_cnt--;
        end
      end
      prev_req  = reset_n && mem_req;
      prev_ack  = mem_ack && mem_req;
      prev_addr = mem_addr;
    end
  end

  task automatic pulse_line(input int row, input bit hr);
    @(negedge clk);
    line_start = 1'b1;
    hires      = hr;
    line_vpos  = 6'(row);
    @(negedge clk);
    line_start = 1'b0;
    hires      = $urandom_range(0, 1);
  endtask

  task automatic start_line(input int row, input bit hr);
    if (fetch_done) begin
      front_valid = pend_valid;
      front_row   = pend_row;
      front_hr    = pend_hr;
    end
    acc_q.delete();
    cur_row    = row;
    cur_hr     = hr;
    fetch_done = 1'b0;
    pulse_line(row, hr);
  endtask

  task automatic finish_fetch(input string tag);
    int n, cyc, bad;
    n = cur_hr ? 32 : 16;
    cyc = 0;
    bad = 0;
    while (acc_q.size() < n && cyc < 4000) begin
      @(negedge clk);
      cyc++;
    end
    check_eq({tag, "_timeout"}, 32'(cyc < 4000), 1);
    repeat (3) @(negedge clk);
    check_eq({tag, "_nreq"}, acc_q.size(), n);
    check_eq({tag, "_idle_req"}, 32'(mem_req), 0);
    for (int k = 0; k < acc_q.size(); k++)
      if (acc_q[k] != exp_addr(cur_row, cur_hr, k)) bad++;
    check_eq({tag, "_addr"}, bad, 0);
    check_eq({tag, "_proto"}, viol, 0);
    pend_row   = cur_row;
    pend_hr    = cur_hr;
    pend_valid = 1'b1;
    fetch_done = 1'b1;
  endtask

  task automatic read_pix(input string tag, input int col);
    @(negedge clk);
    vram_hpos = col[6:0];
    @(posedge clk);
    #1;
    check_eq(tag, 32'(vram_pixel), 32'(ref_pix(front_valid, front_hr, front_row, col)));
  endtask

  task automatic read_rand(input string tag, input int n);
    for (int i = 0; i < n; i++) read_pix(tag, $urandom_range(0, 127));
  endtask

  initial begin
    logic [11:0] first;
    int cyc;
    reset_n    = 1'b0;
    hires      = 1'b0;
    line_start = 1'b0;
    line_vpos  = '0;
    vram_hpos  = '0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    mem[12'h050] = 8'h80;
    mem[12'h450] = 8'h01;
    fetch_done = 1'b0; front_valid = 1'b0; pend_valid = 1'b0;
    front_row = 0; front_hr = 1'b0; pend_row = 0; pend_hr = 1'b0;
    cur_row = 0; cur_hr = 1'b0;

    repeat (3) @(negedge clk);
    check_eq("rst_req", 32'(mem_req), 0);
    check_eq("rst_addr", 32'(mem_addr), 0);
    check_eq("rst_pix", 32'(vram_pixel), 0);
    check_eq("rst_underrun", 32'(underrun), 0);
    reset_n = 1'b1;
    @(negedge clk);

    // hires row 5, ack one cycle after each request
    lat_max = 0;
    start_line(5, 1'b1);
    finish_fetch("hires5");

    // swap to hires row 5 while lores row 3 fetches
    start_line(3, 1'b0);
    @(negedge clk);
    vram_hpos = 7'd0;
    @(posedge clk);
    #1;
    check_eq("pix_col0", 32'(vram_pixel), 32'(2'b01));
    @(negedge clk);
    vram_hpos = 7'd7;
    #1;
    check_eq("pix_latency", 32'(vram_pixel), 32'(2'b01));
    @(posedge clk);
    #1;
    check_eq("pix_col7", 32'(vram_pixel), 32'(2'b10));
    read_rand("pix_hires", 8);
    finish_fetch("lores3");

    // lores row 3 becomes front
    start_line(17, 1'b1);
    read_pix("pix_lores64", 64);
    read_pix("pix_lores127", 127);
    read_pix("pix_lores63", 63);
    read_rand("pix_lores", 8);
    finish_fetch("hires17");

    // random lines with random ack latency
    for (int i = 0; i < 6; i++) begin
      lat_max = $urandom_range(0, 3);
      start_line($urandom_range(0, 63), 1'($urandom_range(0, 1)));
      read_rand("pix_rand", 6);
      finish_fetch("rand_line");
    end

    // underrun: second line_start while a request is stalled
    lat_max  = 0;
    ack_hold = 1'b1;
    start_line(9, 1'b1);
    repeat (4) @(negedge clk);
    check_eq("ur_req_pending", 32'(mem_req), 1);
    check_eq("ur_addr_pending", 32'(mem_addr), 32'(exp_addr(9, 1'b1, 0)));
    check_eq("ur_before", 32'(underrun), 0);
    cur_row = 40;
    cur_hr  = 1'b0;
    pulse_line(40, 1'b0);
    check_eq("ur_flag", 32'(underrun), UR_EN);
    check_eq("ur_req_held", 32'(mem_req), 1);
    read_rand("ur_noswap", 4);
    ack_hold = 1'b0;
    cyc = 0;
    while (acc_q.size() < 1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("ur_drain_timeout", 32'(cyc < 200), 1);
    first = (acc_q.size() > 0) ? acc_q.pop_front() : 12'hFFF;
    check_eq("ur_drain_addr", 32'(first), 32'(exp_addr(9, 1'b1, 0)));
    finish_fetch("ur_restart");
    start_line(50, 1'b1);
    read_pix("ur_swap70", 70);
    read_rand("ur_swap", 6);
    check_eq("ur_sticky", 32'(underrun), UR_EN);
    finish_fetch("hires50");

    // reset in the middle of a request
    ack_hold = 1'b1;
    start_line(20, 1'b1);
    repeat (4) @(negedge clk);
    check_eq("mrst_req_before", 32'(mem_req), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("mrst_req", 32'(mem_req), 0);
    check_eq("mrst_addr", 32'(mem_addr), 0);
    check_eq("mrst_pix", 32'(vram_pixel), 0);
    check_eq("mrst_underrun", 32'(underrun), 0);
    force_ack = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    force_ack = 1'b0;
    ack_hold  = 1'b0;
    check_eq("mrst_idle_req", 32'(mem_req), 0);
    front_valid = 1'b0;
    pend_valid  = 1'b0;
    fetch_done  = 1'b0;
    acc_q.delete();
    for (int c = 0; c < 128; c++) read_pix("mrst_clear", c);
    start_line(33, 1'b1);
    read_rand("mrst_noswap", 4);
    finish_fetch("post_rst");
    start_line(2, 1'b0);
    read_rand("post_rst_pix", 8);
    finish_fetch("lores2");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
